spi_ram_arbiter: RTL
====================

Name: spi_ram_arbiter

Overview:
- Sequences the 10-bit command words from the SPI slave into RAM accesses.
- Shares the single-port RAM between the SPI path and a local host port.
- Decodes command bits [9:8], keeps the write/read address registers, grants one RAM access at a time, and returns read data to the SPI slave via tx_data/tx_valid.
- Sits between the SPI slave and the single-port RAM; the host port serves debug/boot loading.

Parameters:
ADDR_W, 8, RAM address width (command payload width).
DATA_W, 8, RAM data width; must equal ADDR_W.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
spi_rx_valid  in  1  command word valid from SPI slave (level, may stay high several cycles)
spi_rx_data  in  10  command: [9:8] opcode, [7:0] payload
spi_tx_valid  out  1  read data available to SPI slave
spi_tx_data  out  DATA_W  read data to SPI slave
host_req  in  1  host access request; level, fields stable until host_gnt
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  one-cycle pulse in the cycle the host access is issued
host_rvalid  out  1  one-cycle pulse, host_rdata valid
host_rdata  out  DATA_W  host read data
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en with ram_we=0
err_overrun  out  1  sticky: SPI access command lost

Behaviour:
- Reset: all outputs 0; wr_addr=0, rd_addr=0, spi_pend=0, last_gnt=HOST, state IDLE.
- SPI commands act only on the rising edge of spi_rx_valid (registered previous value). A level held high is one command.
- Opcode 00: wr_addr <= payload; no RAM access.
- Opcode 01: queue SPI write with addr=wr_addr and data=payload. spi_pend <= 1; address and data are latched into the pending slot.
- Opcode 10: rd_addr <= payload; no RAM access.
- Opcode 11: queue SPI read with addr=rd_addr; payload ignored; spi_pend <= 1.
- Any rising edge of spi_rx_valid clears spi_tx_valid.
- Opcode 01 or 11 edge while spi_pend=1: command dropped, err_overrun <= 1 until rst. The pending slot is untouched.
- Opcodes 00 and 10 are always accepted, even when a command is pending; the pending slot already holds its own address.
- Pending-slot edge detect is registered: edge sampled at edge t gives spi_pend=1 from t+1.
- FSM states IDLE, ACCESS, RD_CAP.
- IDLE:
  - Exactly one requester (spi_pend or host_req): select it.
  - Both requesting: select the one not equal to last_gnt (round-robin).
  - Selection registers ram_en=1 plus ram_we/addr/wdata and moves to ACCESS. Selection updates last_gnt.
  - Host selected: host_gnt pulses in the ACCESS cycle.
  - SPI selected: spi_pend clears on entering ACCESS.
- ACCESS:
  - ram_en=1 for exactly one cycle.
  - Write: go to IDLE.
  - Read: go to RD_CAP.
- RD_CAP:
  - Capture ram_rdata. SPI read: spi_tx_data <= ram_rdata, spi_tx_valid <= 1, held until the next spi_rx_valid rising edge. Host read: host_rdata <= ram_rdata, host_rvalid pulses one cycle.
  - Go to IDLE.
- ram_en=0 in IDLE and RD_CAP; ram_addr/ram_wdata hold their last values.
- Latency, SPI read: edge sampled at t, ram_en at t+2, spi_tx_valid at t+4. Host read: host_req seen in IDLE at t, host_gnt at t+1, host_rvalid at t+3.
- Throughput: write one per 2 cycles; read one per 3 cycles.
- A host that holds host_req after host_gnt issues a new request. Round-robin keeps it from starving the SPI path.
- rst mid-access: the access is abandoned; ram_en falls next cycle; pending SPI command and spi_tx_valid are lost.

Optional Feature:
SPI_FIXED_PRIO_EN:
- Defined: when both spi_pend and host_req are set, SPI always wins; last_gnt is unused; the host can starve under continuous SPI traffic.
- Undefined (default): round-robin as above.

Test Plan:
- SPI 00 payload 0x3C, then 01 payload 0xA5 -> ram_en=1, ram_we=1, ram_addr=0x3C, ram_wdata=0xA5 two cycles after the 01 edge.
- After the write above, SPI 10 0x3C, then 11 -> ram_en with ram_we=0, ram_addr=0x3C; spi_tx_data=0xA5, spi_tx_valid=1 four cycles after the 11 edge, held; next rx edge clears it.
- spi_pend and host_req (write 0x10<-0x55) rise together, last_gnt=HOST -> SPI granted first, host_gnt one access later; reversed when last_gnt=SPI. With SPI_FIXED_PRIO_EN, SPI always first.
- Host read 0x10 -> host_gnt at t+1, host_rvalid pulse at t+3 with host_rdata=0x55.
- Two 01 edges with the first still pending (host holding the RAM) -> only the first write happens; err_overrun=1 and stays until rst.
- spi_rx_valid held high 5 cycles for one 01 command -> exactly one RAM write. rst asserted during ACCESS -> all outputs 0 next cycle, no spi_tx_valid.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: turns 10-bit SPI command words into RAM accesses and
// shares the single-port RAM with a local host (debug/boot) port.
// Optional build macro SPI_FIXED_PRIO_EN: when defined, a pending SPI access
// always beats a simultaneous host request. When undefined, the two
// requesters alternate (round-robin on last grant).
module spi_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_rx_valid,
  input  logic [ADDR_W+1:0] spi_rx_data,
  output logic              spi_tx_valid,
  output logic [DATA_W-1:0] spi_tx_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              err_overrun
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_CAP} state_t;

  localparam logic [1:0] OP_SET_WA = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SET_RA = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  state_t            state;
  logic              rx_valid_q;
  logic              rx_edge;
  logic [1:0]        opcode;
  logic [ADDR_W-1:0] payload;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  // Pending SPI access slot: holds its own address/data once queued.
  logic              spi_pend;
  logic              pend_we;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;

  // Remembers who owns the access in flight so RD_CAP routes the data.
  logic              cur_spi;

  logic              sel_spi;
  logic              sel_host;

`ifndef SPI_FIXED_PRIO_EN
  // 1 = SPI got the last grant, 0 = host.
  logic              last_gnt_spi;
`endif

  assign rx_edge = spi_rx_valid & ~rx_valid_q;
  assign opcode  = spi_rx_data[ADDR_W+1:ADDR_W];
  assign payload = spi_rx_data[ADDR_W-1:0];

  // Arbitration decision, only meaningful while the FSM is idle.
  always_comb begin
    sel_spi  = 1'b0;
    sel_host = 1'b0;
    if (state == IDLE) begin
      if (spi_pend && host_req) begin
`ifdef SPI_FIXED_PRIO_EN
        sel_spi = 1'b1;
`else
        if (last_gnt_spi) sel_host = 1'b1;
        else              sel_spi  = 1'b1;
`endif
      end else if (spi_pend) begin
        sel_spi = 1'b1;
      end else if (host_req) begin
        sel_host = 1'b1;
      end
    end
  end

  // SPI command front end: edge detect, address registers, pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q  <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      spi_pend    <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rx_valid_q <= spi_rx_valid;
      if (sel_spi) spi_pend <= 1'b0;
      if (rx_edge) begin
        case (opcode)
          OP_SET_WA: wr_addr <= payload;
          OP_SET_RA: rd_addr <= payload;
          OP_WRITE: begin
            if (spi_pend) begin
              err_overrun <= 1'b1;
            end else begin
              spi_pend   <= 1'b1;
              pend_we    <= 1'b1;
              pend_addr  <= wr_addr;
              pend_wdata <= payload;
            end
          end
          default: begin
            if (spi_pend) begin
              err_overrun <= 1'b1;
            end else begin
              spi_pend  <= 1'b1;
              pend_we   <= 1'b0;
              pend_addr <= rd_addr;
            end
          end
        endcase
      end
    end
  end

  // Access FSM with registered RAM strobes and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      host_gnt     <= 1'b0;
      host_rvalid  <= 1'b0;
      host_rdata   <= '0;
      spi_tx_valid <= 1'b0;
      spi_tx_data  <= '0;
      cur_spi      <= 1'b0;
`ifndef SPI_FIXED_PRIO_EN
      last_gnt_spi <= 1'b0;
`endif
    end else begin
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;
      ram_en      <= 1'b0;
      if (rx_edge) spi_tx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_spi) begin
            ram_en   <= 1'b1;
            ram_we   <= pend_we;
            ram_addr <= pend_addr;
            if (pend_we) ram_wdata <= pend_wdata;
            cur_spi  <= 1'b1;
`ifndef SPI_FIXED_PRIO_EN
            last_gnt_spi <= 1'b1;
`endif
            state    <= ACCESS;
          end else if (sel_host) begin
            ram_en   <= 1'b1;
            ram_we   <= host_we;
            ram_addr <= host_addr;
            if (host_we) ram_wdata <= host_wdata;
            host_gnt <= 1'b1;
            cur_spi  <= 1'b0;
`ifndef SPI_FIXED_PRIO_EN
            last_gnt_spi <= 1'b0;
`endif
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          state <= ram_we ? IDLE : RD_CAP;
        end
        RD_CAP: begin
          if (cur_spi) begin
            spi_tx_data  <= ram_rdata;
            spi_tx_valid <= 1'b1;
          end else begin
            host_rdata  <= ram_rdata;
            host_rvalid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
